// File: rtl/debruijn_ctrl_pkg.sv
// debruijn_ctrl_pkg: shared widths, sequence period and FSM state type for the de Bruijn sequencing controller
package debruijn_ctrl_pkg;
  localparam int SEQ_W = 4;
  localparam int PERIOD = 16;
  typedef enum logic {IDLE, RUN} dbc_state_t;
endpackage

// File: rtl/debruijn_seq_ctrl_if.sv
// debruijn_seq_ctrl_if: request, output-stream and generator signals of the sequencing controller
// Ports: none; modport slave is the controller side, modport master is the requester/consumer/generator side.
interface debruijn_seq_ctrl_if
  import debruijn_ctrl_pkg::*;
#(
  parameter int LEN_W = 5
) ();
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [SEQ_W-1:0] req0_seed, req1_seed;
  logic [LEN_W-1:0] req0_len, req1_len;
  logic out_valid, out_ready, out_id, out_last;
  logic [SEQ_W-1:0] out_data, gen_seed, gen_state;
  logic gen_sel, busy;
  modport slave (
    input  req0_valid, req1_valid, req0_seed, req1_seed, req0_len, req1_len, out_ready, gen_state,
    output req0_ready, req1_ready, out_valid, out_data, out_id, out_last, gen_seed, gen_sel, busy
  );
  modport master (
    output req0_valid, req1_valid, req0_seed, req1_seed, req0_len, req1_len, out_ready, gen_state,
    input  req0_ready, req1_ready, out_valid, out_data, out_id, out_last, gen_seed, gen_sel, busy
  );
endinterface

// File: rtl/debruijn_ctrl_arb.sv
// debruijn_ctrl_arb: 2-way request arbiter, round-robin with DEBRUIJN_CTRL_RR_EN, fixed req0 priority otherwise
// Ports: clk/rst (round-robin build only), en (grant allowed), req[1:0] valids, gnt[1:0] one-hot grant.
module debruijn_ctrl_arb
  import debruijn_ctrl_pkg::*;
(
`ifdef DEBRUIJN_CTRL_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
`ifdef DEBRUIJN_CTRL_RR_EN
  logic ptr_q, ptr_d;
  // ptr_q names the favoured requester; every grant hands priority to the other one
  always_comb begin
    gnt = !en ? 2'b00 : (req[0] && (!req[1] || !ptr_q)) ? 2'b01 : req[1] ? 2'b10 : 2'b00;
    ptr_d = (|gnt) ? gnt[0] : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= !rst ? 1'b0 : ptr_d;
`else
  always_comb gnt = en ? {req[1] && !req[0], req[0]} : 2'b00;
`endif
endmodule

// File: rtl/debruijn_seq_ctrl.sv
// debruijn_seq_ctrl: arbitrates burst requests, loads the external de Bruijn generator and streams its states
// Ports: clk, rst (sync, active-low), bus (debruijn_seq_ctrl_if.slave: requests, out stream, generator, busy).
// Build option: DEBRUIJN_CTRL_RR_EN selects round-robin arbitration instead of fixed req0 priority.
module debruijn_seq_ctrl
  import debruijn_ctrl_pkg::*;
#(
  parameter int LEN_W = 5
) (
  input logic              clk,
  input logic              rst,
  debruijn_seq_ctrl_if.slave bus
);
  dbc_state_t state_q, state_d;
  logic id_q, id_d;
  logic [LEN_W-1:0] remaining_q, remaining_d, grant_len;
  logic [1:0] gnt;
  logic run, step;
  debruijn_ctrl_arb u_arb (
`ifdef DEBRUIJN_CTRL_RR_EN
    .clk(clk),
    .rst(rst),
`endif
    .en(rst && state_q == IDLE),
    .req({bus.req1_valid, bus.req0_valid}),
    .gnt(gnt)
  );
  // Outputs are forced to their reset values while rst is low; a stalled or idle
  // generator is held by reloading its own state.
  always_comb begin
    run = rst && state_q == RUN;
    step = run && bus.out_ready;
    grant_len = gnt[1] ? bus.req1_len : bus.req0_len;
    bus.req0_ready = gnt[0];
    bus.req1_ready = gnt[1];
    bus.out_valid = run;
    bus.out_data = bus.gen_state;
    bus.out_id = rst && id_q;
    bus.out_last = run && remaining_q == LEN_W'(1);
    bus.busy = run;
    bus.gen_sel = step;
    bus.gen_seed = !rst ? '0 : gnt[1] ? bus.req1_seed : gnt[0] ? bus.req0_seed : bus.gen_state;
    state_d = state_q;
    id_d = id_q;
    remaining_d = remaining_q;
    if (|gnt) begin
      id_d = gnt[1];
      remaining_d = grant_len;
      state_d = (grant_len != '0) ? RUN : IDLE;
    end else if (step) begin
      remaining_d = (remaining_q != '0) ? remaining_q - LEN_W'(1) : remaining_q;
      state_d = (remaining_q == LEN_W'(1)) ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      remaining_q <= remaining_d;
    end
  end
endmodule
